c2c_link_hndlr: RTL
===================

Name: c2c_link_hndlr

Overview:
- Link-loss handler for the chip-to-chip AXI bridge.
- Watches c2c_link_status and the AXI handshakes crossing the bridge, and tracks outstanding read and write transactions.
- On link loss it blocks new requests, drains or abandons in-flight transactions, then waits for a stable link before reopening.
- Drives c2c_link_hndlr_in_prog, which the reset handler consumes; while it is high the reset handler holds off, and when it falls the reset handler issues a bridge reset.

Parameters:
FREQ, 188000000, c2c_aclk frequency in Hz
DIV, 1000, drain timeout = FREQ/DIV cycles (1 ms default)
STABLE_CYCLES, 64, consecutive link-up cycles required before reopening
OUTST_W, 6, width of each outstanding-transaction counter

Ports:
c2c_aclk  in  1  clock
c2c_aresetn  in  1  asynchronous active-low reset
c2c_link_status  in  1  link up, synchronous to c2c_aclk
c2c_awvalid / c2c_awready  in  1 each  AW handshake observation
c2c_bvalid / c2c_bready  in  1 each  B handshake observation
c2c_arvalid / c2c_arready  in  1 each  AR handshake observation
c2c_rvalid / c2c_rready / c2c_rlast  in  1 each  R handshake observation
c2c_clr_error  in  1  clears sticky flags
c2c_link_hndlr_in_prog  out  1  link handling active
c2c_axi_block  out  1  gate new AW/AR requests at the master side
c2c_drain_timeout  out  1  sticky: drain abandoned with transactions outstanding
c2c_cnt_underflow  out  1  sticky: response seen with counter at 0
c2c_wr_outst  out  OUTST_W  outstanding writes
c2c_rd_outst  out  OUTST_W  outstanding reads

Behaviour:
- Reset is asynchronous. Reset values:
  - state = LINK_DOWN
  - in_prog = 0, axi_block = 1
  - both flags = 0, both counters = 0
  - stable counter = 0, timeout counter = 0
- All outputs are registered and decoded from state_next, so an output changes on the same edge that the state changes.
- Counters:
  - wr: +1 on awvalid&awready; -1 on bvalid&bready; both in the same cycle gives no change.
  - rd: +1 on arvalid&arready; -1 on rvalid&rready&rlast; same simultaneous-event rule.
  - Increment at all-ones saturates.
  - Decrement at 0 holds 0 and sets c2c_cnt_underflow.
- Stable counter:
  - Counts up while c2c_link_status=1; clears to 0 when it is 0.
  - Saturates at STABLE_CYCLES.
  - link_ok = (stable counter == STABLE_CYCLES).
- Timeout counter: counts only in DRAIN; otherwise 0. Timeout when it reaches >= FREQ/DIV.
- States:
  - LINK_DOWN (axi_block=1, in_prog=0): go to ACTIVE when link_ok.
  - ACTIVE (axi_block=0, in_prog=0): go to DRAIN when c2c_link_status=0.
  - DRAIN (axi_block=1, in_prog=1):
    - If wr=0 and rd=0, go to RECOVER.
    - Else if timeout, go to RECOVER, set c2c_drain_timeout, and force both counters to 0 on that edge.
    - Counters reaching 0 on the same cycle as timeout: drain completion wins; no flag.
    - Link returning during DRAIN does not end DRAIN.
  - RECOVER (axi_block=1, in_prog=1): go to LINK_DOWN when link_ok. The stable counter restarts on every link glitch.
- Handshakes keep updating the counters in every state. Handshakes observed in RECOVER/LINK_DOWN count normally.
- c2c_clr_error=1 clears both sticky flags that cycle. A set event in the same cycle wins over clear.
- Reset mid-operation (any state): immediate return to LINK_DOWN values. No drain is attempted.
- Timeout arithmetic: 32-bit counter compared against localparam FREQ/DIV (integer division).

Decomposition:
- Package c2c_pkg holds:
  - the link-handler state enum (LINK_DOWN, ACTIVE, DRAIN, RECOVER; 2-bit logic);
  - a function computing the timeout from FREQ/DIV.
- One sub-module c2c_outst_cntr (parameter OUTST_W):
  - inputs: inc, dec, force_clr;
  - outputs: count, underflow pulse;
  - instantiated twice (write and read).

Test Plan (bench params FREQ=1000, DIV=100 giving timeout 10; STABLE_CYCLES=4; OUTST_W=3):
1. Release reset with link_status=1 -> axi_block falls exactly 4 cycles after the first link-up cycle; in_prog stays 0; counters 0.
2. In ACTIVE, 3 AW handshakes then link_status=0, then 3 B handshakes over 5 cycles -> in_prog=1 and axi_block=1 on the edge after link drop; RECOVER when wr=0; no timeout flag.
3. 2 AR handshakes, drop link, no R responses -> c2c_drain_timeout=1 after 10 DRAIN cycles; rd_outst forced to 0; c2c_clr_error pulse clears the flag.
4. In RECOVER, link toggles 1,1,1,0,1,1,1,1 -> ACTIVE/LINK_DOWN is reached only after the final 4-cycle run; in_prog falls entering LINK_DOWN.
5. AW and B handshakes in the same cycle with wr=2 -> wr stays 2. B handshake with wr=0 -> wr stays 0 and c2c_cnt_underflow=1. 8 AWs with no responses -> wr saturates at 7.
6. Assert c2c_aresetn=0 mid-DRAIN, asynchronously between edges -> outputs return to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/c2c_pkg.sv
// -----------------------------------------------------------------------------
// c2c_pkg
// Shared types and helpers for the chip-to-chip link-loss handler.
//   lh_state_e           : link-handler FSM state encoding (2-bit)
//   drain_timeout_cycles : number of c2c_aclk cycles a drain may last
// -----------------------------------------------------------------------------
package c2c_pkg;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,  // link not yet proven stable, requests blocked
    ACTIVE    = 2'd1,  // normal operation, requests flow
    DRAIN     = 2'd2,  // link lost, waiting for outstanding responses
    RECOVER   = 2'd3   // drain finished, waiting for a stable link
  } lh_state_e;

  // Drain timeout in clock cycles: FREQ/DIV with integer division. A DIV of
  // zero is treated as one so a misconfigured instance still elaborates.
  function automatic int unsigned drain_timeout_cycles(input int unsigned freq,
                                                       input int unsigned div);
    int unsigned safe_div;
    safe_div = (div == 0) ? 1 : div;
    return freq / safe_div;
  endfunction

endpackage

// File: rtl/c2c_outst_cntr.sv
// -----------------------------------------------------------------------------
// c2c_outst_cntr
// Outstanding-transaction counter for one direction (write or read).
//   c2c_aclk, c2c_aresetn : clock, asynchronous active-low reset
//   inc                   : request handshake accepted this cycle
//   dec                   : final response handshake accepted this cycle
//   force_clr             : abandon everything outstanding (wins over inc/dec)
//   count                 : registered number of outstanding transactions
//   underflow             : combinational pulse, response seen with count at 0
// An increment at all-ones saturates; a decrement at zero holds zero.
// Simultaneous inc and dec cancel out and never flag an underflow.
// -----------------------------------------------------------------------------
module c2c_outst_cntr #(
  parameter int unsigned OUTST_W = 6
) (
  input  logic               c2c_aclk,
  input  logic               c2c_aresetn,
  input  logic               inc,
  input  logic               dec,
  input  logic               force_clr,
  output logic [OUTST_W-1:0] count,
  output logic               underflow
);

  localparam logic [OUTST_W-1:0] CNT_MAX = '1;

  logic inc_only;
  logic dec_only;

  assign inc_only  = inc && !dec;
  assign dec_only  = dec && !inc;
  assign underflow = dec_only && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
    if (!c2c_aresetn) begin
      count <= '0;
    end else if (force_clr) begin
      count <= '0;
    end else if (inc_only && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end else if (dec_only && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/c2c_link_hndlr.sv
// -----------------------------------------------------------------------------
// c2c_link_hndlr
// Link-loss handler for the chip-to-chip AXI bridge. Tracks outstanding
// reads/writes from observed handshakes; on link loss it blocks new requests,
// drains (or abandons after a timeout) in-flight transactions, then waits for
// a stable link before reopening. c2c_link_hndlr_in_prog holds off the reset
// handler; its falling edge tells the reset handler to reset the bridge.
//
// Ports:
//   c2c_aclk, c2c_aresetn        : clock, asynchronous active-low reset
//   c2c_link_status              : link up, synchronous to c2c_aclk
//   c2c_aw/b/ar/r valid/ready    : AXI handshake observation (rlast on R)
//   c2c_clr_error                : clears the sticky error flags
//   c2c_link_hndlr_in_prog       : link handling active (DRAIN/RECOVER)
//   c2c_axi_block                : gate new AW/AR at the master side
//   c2c_drain_timeout            : sticky, drain abandoned with work pending
//   c2c_cnt_underflow            : sticky, response seen with counter at 0
//   c2c_wr_outst, c2c_rd_outst   : outstanding write / read counts
//
// All outputs are registered. FSM outputs are decoded from state_next so they
// change on the same edge as the state.
// -----------------------------------------------------------------------------
module c2c_link_hndlr
  import c2c_pkg::*;
#(
  parameter int unsigned FREQ          = 188000000,
  parameter int unsigned DIV           = 1000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned OUTST_W       = 6
) (
  input  logic               c2c_aclk,
  input  logic               c2c_aresetn,
  input  logic               c2c_link_status,
  input  logic               c2c_awvalid,
  input  logic               c2c_awready,
  input  logic               c2c_bvalid,
  input  logic               c2c_bready,
  input  logic               c2c_arvalid,
  input  logic               c2c_arready,
  input  logic               c2c_rvalid,
  input  logic               c2c_rready,
  input  logic               c2c_rlast,
  input  logic               c2c_clr_error,
  output logic               c2c_link_hndlr_in_prog,
  output logic               c2c_axi_block,
  output logic               c2c_drain_timeout,
  output logic               c2c_cnt_underflow,
  output logic [OUTST_W-1:0] c2c_wr_outst,
  output logic [OUTST_W-1:0] c2c_rd_outst
);

  localparam int unsigned         TIMEOUT_CYCLES = drain_timeout_cycles(FREQ, DIV);
  localparam int unsigned         STABLE_W       = $clog2(STABLE_CYCLES + 1);
  localparam logic [STABLE_W-1:0] STABLE_MAX     = STABLE_W'(STABLE_CYCLES);

  lh_state_e           state;
  lh_state_e           state_next;
  logic [STABLE_W-1:0] stable_cnt;
  logic [31:0]         tmo_cnt;

  logic link_ok;
  logic tmo_hit;
  logic outst_any;
  logic drain_abandon;
  logic aw_hs, b_hs, ar_hs, r_hs;
  logic wr_unf, rd_unf;

  // ---------------------------------------------------------------------------
  // Handshake observation. A read completes only on its last R beat.
  // ---------------------------------------------------------------------------
  assign aw_hs = c2c_awvalid && c2c_awready;
  assign b_hs  = c2c_bvalid  && c2c_bready;
  assign ar_hs = c2c_arvalid && c2c_arready;
  assign r_hs  = c2c_rvalid  && c2c_rready && c2c_rlast;

  // ---------------------------------------------------------------------------
  // Outstanding counters. Handshakes count in every state; a drain abandoned
  // on timeout forgets whatever was still outstanding.
  // ---------------------------------------------------------------------------
  c2c_outst_cntr #(
    .OUTST_W (OUTST_W)
  ) u_wr_cntr (
    .c2c_aclk    (c2c_aclk),
    .c2c_aresetn (c2c_aresetn),
    .inc         (aw_hs),
    .dec         (b_hs),
    .force_clr   (drain_abandon),
    .count       (c2c_wr_outst),
    .underflow   (wr_unf)
  );

  c2c_outst_cntr #(
    .OUTST_W (OUTST_W)
  ) u_rd_cntr (
    .c2c_aclk    (c2c_aclk),
    .c2c_aresetn (c2c_aresetn),
    .inc         (ar_hs),
    .dec         (r_hs),
    .force_clr   (drain_abandon),
    .count       (c2c_rd_outst),
    .underflow   (rd_unf)
  );

  assign outst_any = (c2c_wr_outst != '0) || (c2c_rd_outst != '0);

  // ---------------------------------------------------------------------------
  // Link stability: consecutive link-up cycles, restarted by any glitch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
    if (!c2c_aresetn) begin
      stable_cnt <= '0;
    end else if (!c2c_link_status) begin
      stable_cnt <= '0;
    end else if (stable_cnt != STABLE_MAX) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign link_ok = (stable_cnt == STABLE_MAX);

  // ---------------------------------------------------------------------------
  // Drain timer: counts the cycles already spent in DRAIN, zero elsewhere.
  // ---------------------------------------------------------------------------
  always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
    if (!c2c_aresetn) begin
      tmo_cnt <= '0;
    end else if (state == DRAIN) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt >= TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Next-state logic. Drain completion is tested first so counters reaching
  // zero in the timeout cycle end the drain cleanly without an error. A link
  // that comes back during DRAIN is ignored: in-flight work is resolved first.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    drain_abandon = 1'b0;
    case (state)
      LINK_DOWN: if (link_ok)          state_next = ACTIVE;
      ACTIVE:    if (!c2c_link_status) state_next = DRAIN;
      DRAIN: begin
        if (!outst_any) begin
          state_next = RECOVER;
        end else if (tmo_hit) begin
          state_next    = RECOVER;
          drain_abandon = 1'b1;
        end
      end
      RECOVER:   if (link_ok)          state_next = LINK_DOWN;
      default:                         state_next = LINK_DOWN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register with registered, next-state-decoded outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
    if (!c2c_aresetn) begin
      state                  <= LINK_DOWN;
      c2c_link_hndlr_in_prog <= 1'b0;
      c2c_axi_block          <= 1'b1;
    end else begin
      state                  <= state_next;
      c2c_link_hndlr_in_prog <= (state_next == DRAIN) || (state_next == RECOVER);
      c2c_axi_block          <= (state_next != ACTIVE);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set event in the same cycle wins over a clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
    if (!c2c_aresetn) begin
      c2c_drain_timeout <= 1'b0;
      c2c_cnt_underflow <= 1'b0;
    end else begin
      if (drain_abandon) begin
        c2c_drain_timeout <= 1'b1;
      end else if (c2c_clr_error) begin
        c2c_drain_timeout <= 1'b0;
      end

      if (wr_unf || rd_unf) begin
        c2c_cnt_underflow <= 1'b1;
      end else if (c2c_clr_error) begin
        c2c_cnt_underflow <= 1'b0;
      end
    end
  end

endmodule
